// File: rtl/exu_hazard_ctrl.sv
// Register scoreboard and issue gate between decode and execute.
// Optional execute-stage bypass is compiled in with `define EXU_HAZARD_FWD_EN.
module exu_hazard_ctrl #(
    parameter int unsigned CNT_W = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_use_rs1,
    input  logic        issue_use_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_wen,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        wb_wen,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    output logic        fwd_rs1,
    output logic        fwd_rs2,
    output logic        busy,
    output logic        sb_err,
    output logic [31:0] stall_cycles
);

    localparam int unsigned NREG = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt [1:NREG-1];
    logic [CNT_W-1:0] w_cnt [0:NREG-1];
    logic             r_sb_err;
    logic [31:0]      r_stall_cycles;

    logic             w_hit1, w_hit2, w_waw;
    logic             w_byp1, w_byp2;
    logic             w_fire, w_inc, w_dec;
    logic [NREG-1:0]  w_inc_vec, w_dec_vec;

    // x0 is never tracked and reads as zero.
    always_comb begin
        w_cnt[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            w_cnt[i] = r_cnt[i];
        end
    end

    assign w_hit1 = issue_use_rs1 && (issue_rs1 != 5'd0) && (w_cnt[issue_rs1] != '0);
    assign w_hit2 = issue_use_rs2 && (issue_rs2 != 5'd0) && (w_cnt[issue_rs2] != '0);
    assign w_waw  = issue_wen && (issue_rd != 5'd0) && (w_cnt[issue_rd] == CNT_MAX);

`ifdef EXU_HAZARD_FWD_EN
    // Bypass only a single outstanding ALU write that is sitting in execute.
    assign w_byp1  = ex_valid && !ex_is_load && (ex_rd == issue_rs1)
                     && (w_cnt[issue_rs1] == CNT_W'(1));
    assign w_byp2  = ex_valid && !ex_is_load && (ex_rd == issue_rs2)
                     && (w_cnt[issue_rs2] == CNT_W'(1));
    assign fwd_rs1 = issue_valid && w_hit1 && w_byp1;
    assign fwd_rs2 = issue_valid && w_hit2 && w_byp2;
`else
    logic w_unused_ex;
    assign w_unused_ex = ^{ex_valid, ex_is_load, ex_rd};
    assign w_byp1  = 1'b0;
    assign w_byp2  = 1'b0;
    assign fwd_rs1 = 1'b0;
    assign fwd_rs2 = 1'b0;
`endif

    assign issue_ready = !flush && (!w_hit1 || w_byp1) && (!w_hit2 || w_byp2) && !w_waw;

    assign w_fire    = issue_valid && issue_ready;
    assign w_inc     = w_fire && issue_wen && (issue_rd != 5'd0);
    assign w_dec     = wb_valid && wb_wen && (wb_rd != 5'd0);
    assign w_inc_vec = w_inc ? (NREG'(1) << issue_rd) : '0;
    assign w_dec_vec = w_dec ? (NREG'(1) << wb_rd) : '0;

    always_comb begin
        busy = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            busy = busy | (r_cnt[i] != '0);
        end
    end

    // Same-register increment and decrement cancel; out-of-range updates are dropped and flagged.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_sb_err       <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_inc_vec[i] && !w_dec_vec[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_sb_err <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
                    if (r_cnt[i] == '0) begin
                        r_sb_err <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    end
                end
            end
            if (issue_valid && !issue_ready && !flush) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign sb_err       = r_sb_err;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_exu_hazard_ctrl.sv
// Scoreboard bench for exu_hazard_ctrl: directed scenarios followed by random traffic.
module tb_exu_hazard_ctrl;

    localparam int unsigned CNT_W = 2;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_use_rs1, issue_use_rs2, issue_wen;
    logic        wb_valid, wb_wen;
    logic [4:0]  wb_rd;
    logic        flush, ex_valid, ex_is_load;
    logic [4:0]  ex_rd;
    logic        fwd_rs1, fwd_rs2, busy, sb_err;
    logic [31:0] stall_cycles;

    always #5 clock = ~clock;

    exu_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_rd(issue_rd), .issue_wen(issue_wen),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .flush(flush), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .busy(busy),
        .sb_err(sb_err), .stall_cycles(stall_cycles)
    );

    typedef struct {
        bit       rst, iv, u1, u2, wen, wbv, wbwen, fl, exv, exld;
        bit [4:0] rs1, rs2, rd, wbrd, exrd;
    } vec_t;

    typedef struct {
        bit        rdy, f1, f2, busy, err;
        bit [31:0] stall;
        int        id;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   done = 1'b0;

    // Reference model: pending-write counts per architectural register.
    int        m_cnt[32];
    bit        m_err;
    bit [31:0] m_stall;

    function automatic vec_t idle();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic vec_t iss(input bit [4:0] rs1, input bit u1, input bit [4:0] rs2,
                                 input bit u2, input bit [4:0] rd, input bit wen);
        vec_t v;
        v = idle();
        v.iv = 1; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.wen = wen;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        bit   h1, h2, b1, b2, waw, inc, dec;
        @(posedge clock);
        #1;
        reset = v.rst; issue_valid = v.iv; issue_rs1 = v.rs1; issue_rs2 = v.rs2;
        issue_use_rs1 = v.u1; issue_use_rs2 = v.u2; issue_rd = v.rd; issue_wen = v.wen;
        wb_valid = v.wbv; wb_rd = v.wbrd; wb_wen = v.wbwen; flush = v.fl;
        ex_valid = v.exv; ex_rd = v.exrd; ex_is_load = v.exld;

        h1 = v.u1 && v.rs1 != 0 && m_cnt[v.rs1] > 0;
        h2 = v.u2 && v.rs2 != 0 && m_cnt[v.rs2] > 0;
`ifdef EXU_HAZARD_FWD_EN
        b1 = v.exv && !v.exld && v.exrd == v.rs1 && m_cnt[v.rs1] == 1;
        b2 = v.exv && !v.exld && v.exrd == v.rs2 && m_cnt[v.rs2] == 1;
`else
        b1 = 0;
        b2 = 0;
`endif
        waw    = v.wen && v.rd != 0 && m_cnt[v.rd] == MAXC;
        e.rdy  = !v.fl && !(h1 && !b1) && !(h2 && !b2) && !waw;
        e.f1   = v.iv && h1 && b1;
        e.f2   = v.iv && h2 && b2;
        e.busy = 0;
        foreach (m_cnt[i]) if (m_cnt[i] > 0) e.busy = 1;
        e.err   = m_err;
        e.stall = m_stall;
        e.id    = vectors + q.size();
        q.push_back(e);

        if (v.rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_err   = 0;
            m_stall = 0;
        end else begin
            if (v.iv && !e.rdy && !v.fl) m_stall = m_stall + 1;
            inc = v.iv && e.rdy && v.wen && v.rd != 0;
            dec = v.wbv && v.wbwen && v.wbrd != 0;
            if (inc && dec && v.rd == v.wbrd) begin
                // same register: net zero change
            end else begin
                if (inc) begin
                    if (m_cnt[v.rd] == MAXC) m_err = 1; else m_cnt[v.rd]++;
                end
                if (dec) begin
                    if (m_cnt[v.wbrd] == 0) m_err = 1; else m_cnt[v.wbrd]--;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %h expected %h", name, id, act, req);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                chk("issue_ready", e.id, 32'(issue_ready), 32'(e.rdy));
                chk("fwd_rs1", e.id, 32'(fwd_rs1), 32'(e.f1));
                chk("fwd_rs2", e.id, 32'(fwd_rs2), 32'(e.f2));
                chk("busy", e.id, 32'(busy), 32'(e.busy));
                chk("sb_err", e.id, 32'(sb_err), 32'(e.err));
                chk("stall_cycles", e.id, stall_cycles, e.stall);
            end else if (done) begin
                break;
            end
        end
    end

    initial begin
        vec_t v;
        int   t;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_err = 0;
        m_stall = 0;
        v = idle();
        v.rst = 1;
        reset = 1; issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_use_rs1 = 0;
        issue_use_rs2 = 0; issue_rd = 0; issue_wen = 0; wb_valid = 0; wb_rd = 0; wb_wen = 0;
        flush = 0; ex_valid = 0; ex_rd = 0; ex_is_load = 0;
        repeat (2) @(posedge clock);
        apply(v);
        apply(idle());

        // RAW on x5, released the cycle after its writeback
        apply(iss(0, 0, 0, 0, 5, 1));
        repeat (3) apply(iss(5, 1, 0, 0, 6, 1));
        v = iss(5, 1, 0, 0, 6, 1); v.wbv = 1; v.wbrd = 5; v.wbwen = 1;
        apply(v);
        apply(iss(5, 1, 0, 0, 6, 1));
        v = idle(); v.wbv = 1; v.wbrd = 6; v.wbwen = 1;
        apply(v);

        // x0 is never tracked
        repeat (3) apply(iss(0, 0, 0, 0, 0, 1));
        apply(iss(0, 1, 0, 1, 0, 0));

        // Saturation on x7, then same-cycle issue plus writeback
        repeat (4) apply(iss(0, 0, 0, 0, 7, 1));
        v = idle(); v.wbv = 1; v.wbrd = 7; v.wbwen = 1;
        apply(v);
        v = iss(0, 0, 0, 0, 7, 1); v.wbv = 1; v.wbrd = 7; v.wbwen = 1;
        apply(v);
        repeat (2) apply(iss(0, 0, 0, 0, 7, 1));
        // Underflow on x9
        v = idle(); v.wbv = 1; v.wbrd = 9; v.wbwen = 1;
        apply(v);
        apply(idle());

        // Flush squashes a hazard-free issue
        v = iss(1, 1, 2, 1, 10, 1); v.fl = 1;
        apply(v);
        apply(iss(10, 1, 0, 0, 0, 0));

        // Bypass from an ALU op in execute, then load-use
        apply(iss(0, 0, 0, 0, 3, 1));
        v = iss(0, 0, 3, 1, 11, 1); v.exv = 1; v.exrd = 3;
        apply(v);
        v = iss(0, 0, 3, 1, 0, 0); v.exv = 1; v.exrd = 3; v.exld = 1;
        apply(v);

        // Reset with pending x4 writes
        v = idle(); v.rst = 1;
        apply(v);
        repeat (2) apply(iss(0, 0, 0, 0, 4, 1));
        apply(iss(4, 1, 0, 0, 0, 0));
        v = idle(); v.rst = 1;
        apply(v);
        apply(iss(4, 1, 0, 0, 0, 0));

        for (int n = 0; n < 3000; n++) begin
            v = idle();
            v.rst   = ($urandom_range(299) == 0);
            v.iv    = ($urandom_range(3) != 0);
            v.rs1   = 5'($urandom_range(7));
            v.rs2   = 5'($urandom_range(7));
            v.u1    = $urandom_range(1);
            v.u2    = $urandom_range(1);
            v.rd    = 5'($urandom_range(7));
            v.wen   = ($urandom_range(3) != 0);
            v.wbrd  = 5'($urandom_range(7));
            v.wbwen = ($urandom_range(7) != 0);
            v.wbv   = ($urandom_range(1) == 1) && (m_cnt[v.wbrd] > 0 || $urandom_range(19) == 0);
            v.fl    = ($urandom_range(7) == 0);
            v.exv   = $urandom_range(1);
            v.exrd  = ($urandom_range(1) == 1) ? v.rs1 : (($urandom_range(1) == 1) ? v.rs2 : 5'($urandom_range(7)));
            v.exld  = ($urandom_range(3) == 0);
            apply(v);
        end

        apply(idle());
        done = 1'b1;
        t = 0;
        while (q.size() > 0 && t < 10) begin
            @(posedge clock);
            t++;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
